e_clk_window_gen: RTL and testbench



---
 rtl/e_clk_pkg.sv | 14 +
 rtl/e_clk_window_ch.sv | 95 +++++++++
 rtl/e_clk_window_gen.sv | 89 ++++++++
 tb/tb_e_clk_window_gen.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/e_clk_pkg.sv
// Shared types and default widths for the E-clock window generator.
package e_clk_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RISE_WAIT = 2'd1,
    ACTIVE    = 2'd2,
    HOLD      = 2'd3
  } ch_state_e;

  localparam int DEF_CNT_W     = 7;
  localparam int DEF_TIMEOUT_W = 12;

endpackage

// File: rtl/e_clk_window_ch.sv
// One enable channel: delay after E rise, hold after E fall, registered output.
import e_clk_pkg::*;

module e_clk_window_ch #(
  parameter int CNT_W   = DEF_CNT_W,
  parameter bit ACT_LOW = 1'b0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_rise,
  input  logic             i_fall,
  input  logic             i_ch_en,
  input  logic [CNT_W-1:0] i_rise_dly,
  input  logic [CNT_W-1:0] i_fall_hold,
  output logic             o_en
);

  localparam logic EN_ON  = !ACT_LOW;
  localparam logic EN_OFF = ACT_LOW;

  ch_state_e        r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_hold;
  logic             r_en;

  // The rise delay is consumed in the same cycle the rise arrives, so only
  // the fall hold needs a local copy that survives until the fall.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_hold  <= '0;
      r_en    <= EN_OFF;
    end else begin
      if (i_rise) r_hold <= i_fall_hold;
      if (!i_ch_en) begin
        r_state <= IDLE;
        r_en    <= EN_OFF;
      end else begin
        case (r_state)
          IDLE: begin
            if (i_rise) begin
              if (i_rise_dly == '0) begin
                r_state <= ACTIVE;
                r_en    <= EN_ON;
              end else begin
                r_cnt   <= i_rise_dly - CNT_W'(1);
                r_state <= RISE_WAIT;
              end
            end
          end
          RISE_WAIT: begin
            if (i_fall) begin
              r_state <= IDLE;
            end else if (r_cnt == '0) begin
              r_state <= ACTIVE;
              r_en    <= EN_ON;
            end else begin
              r_cnt <= r_cnt - CNT_W'(1);
            end
          end
          ACTIVE: begin
            if (i_fall) begin
              if (r_hold == '0) begin
                r_state <= IDLE;
                r_en    <= EN_OFF;
              end else begin
                r_cnt   <= r_hold - CNT_W'(1);
                r_state <= HOLD;
              end
            end
          end
          HOLD: begin
            // A new rise during the hold merges the two windows seamlessly.
            if (i_rise) begin
              r_state <= ACTIVE;
            end else if (r_cnt == '0) begin
              r_state <= IDLE;
              r_en    <= EN_OFF;
            end else begin
              r_cnt <= r_cnt - CNT_W'(1);
            end
          end
          default: begin
            r_state <= IDLE;
            r_en    <= EN_OFF;
          end
        endcase
      end
    end
  end

  assign o_en = r_en;

endmodule

// File: rtl/e_clk_window_gen.sv
// 6809 E-clock synchroniser, edge detector, stuck-E watchdog and per-channel
// buffer-enable window generators.
import e_clk_pkg::*;

module e_clk_window_gen #(
  parameter int                NUM_CH          = 2,
  parameter int                CNT_W           = DEF_CNT_W,
  parameter int                SYNC_STAGES     = 2,
  parameter int                TIMEOUT_W       = DEF_TIMEOUT_W,
  parameter logic [NUM_CH-1:0] ACTIVE_LOW_MASK = {NUM_CH{1'b0}}
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_e_clk,
  input  logic [NUM_CH*CNT_W-1:0] i_rise_dly,
  input  logic [NUM_CH*CNT_W-1:0] i_fall_hold,
  input  logic [NUM_CH-1:0]       i_ch_en,
  output logic [NUM_CH-1:0]       o_en,
  output logic                    o_e_sync,
  output logic                    o_e_timeout
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [SYNC_STAGES:0]   r_vld;
  logic                   r_e_d;
  logic                   r_rise;
  logic                   r_fall;
  logic [TIMEOUT_W-1:0]   r_wd;
  logic                   r_timeout;

  logic                   w_e_s;
  logic                   w_rise;
  logic                   w_fall;
  logic [TIMEOUT_W-1:0]   w_wd_nxt;

  // Edges are qualified until e_s and e_d both hold real samples, so a
  // release from reset with E already high is not mistaken for a rise.
  assign w_e_s  = r_sync[SYNC_STAGES-1];
  assign w_rise = r_vld[SYNC_STAGES] & w_e_s & ~r_e_d;
  assign w_fall = r_vld[SYNC_STAGES] & ~w_e_s & r_e_d;

  always_comb begin
    w_wd_nxt = r_wd;
    if (r_rise | r_fall)
      w_wd_nxt = '0;
    else if (r_wd != {TIMEOUT_W{1'b1}})
      w_wd_nxt = r_wd + TIMEOUT_W'(1);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync    <= '0;
      r_vld     <= '0;
      r_e_d     <= 1'b0;
      r_rise    <= 1'b0;
      r_fall    <= 1'b0;
      r_wd      <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_sync    <= {r_sync[SYNC_STAGES-2:0], i_e_clk};
      r_vld     <= {r_vld[SYNC_STAGES-1:0], 1'b1};
      r_e_d     <= w_e_s;
      r_rise    <= w_rise;
      r_fall    <= w_fall;
      r_wd      <= w_wd_nxt;
      r_timeout <= (w_wd_nxt == {TIMEOUT_W{1'b1}});
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    e_clk_window_ch #(
      .CNT_W   (CNT_W),
      .ACT_LOW (ACTIVE_LOW_MASK[k])
    ) u_ch (
      .i_clk       (i_clk),
      .i_rst_n     (i_rst_n),
      .i_rise      (r_rise),
      .i_fall      (r_fall),
      .i_ch_en     (i_ch_en[k]),
      .i_rise_dly  (i_rise_dly[k*CNT_W +: CNT_W]),
      .i_fall_hold (i_fall_hold[k*CNT_W +: CNT_W]),
      .o_en        (o_en[k])
    );
  end

  assign o_e_sync    = w_e_s;
  assign o_e_timeout = r_timeout;

endmodule

// File: tb/tb_e_clk_window_gen.sv
// Bench for e_clk_window_gen: window timing model driven by E edge times.
module tb_e_clk_window_gen;

  localparam int INF = 1 << 30;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        e = 1'b0;
  logic [13:0] rdly = '0;
  logic [13:0] fhold = '0;
  logic [1:0]  chen = '0;
  logic [1:0]  o_en;
  logic        o_e_sync;
  logic        o_e_timeout;

  always #5 clk = ~clk;

  e_clk_window_gen #(
    .NUM_CH          (2),
    .CNT_W           (7),
    .SYNC_STAGES     (2),
    .TIMEOUT_W       (12),
    .ACTIVE_LOW_MASK (2'b10)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_e_clk     (e),
    .i_rise_dly  (rdly),
    .i_fall_hold (fhold),
    .i_ch_en     (chen),
    .o_en        (o_en),
    .o_e_sync    (o_e_sync),
    .o_e_timeout (o_e_timeout)
  );

  int   tests = 0;
  int   fails = 0;
  int   cyc = 10;
  logic pin_h [0:32767];
  logic [1:0] mask_v = 2'b10;
  int   asrt [2];
  int   deas [2];
  int   hl [2];
  int   last_edge = 0;
  int   rel_cyc = 0;
  bit   model_ok = 1'b0;

  typedef struct {
    int d; int h; int hi; int lo; int exp_on; int exp_off;
  } vec_t;
  vec_t tbl [7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  function automatic bit act_m(input int k, input int c);
    return (asrt[k] <= c) && (c < deas[k]);
  endfunction

  // One cycle: check outputs of this cycle, then drive inputs and advance the model.
  task automatic step(input logic e_v, input logic [1:0] en_v,
                      input int d0, input int h0, input int d1, input int h1);
    bit rs, fl;
    int d, h;
    @(negedge clk);
    cyc++;
    if (model_ok) begin
      for (int k = 0; k < 2; k++)
        chk($sformatf("en%0d", k), 64'(o_en[k]), 64'(act_m(k, cyc) ^ mask_v[k]));
      chk("timeout", 64'(o_e_timeout), 64'((cyc - last_edge - 1) >= 4095));
      if (cyc >= rel_cyc + 2) chk("e_sync", 64'(o_e_sync), 64'(pin_h[cyc-2]));
    end
    e     = e_v;
    chen  = en_v;
    rdly  = {7'(d1), 7'(d0)};
    fhold = {7'(h1), 7'(h0)};
    pin_h[cyc] = e_v;
    if (model_ok) begin
      rs = pin_h[cyc-3] & ~pin_h[cyc-4];
      fl = ~pin_h[cyc-3] & pin_h[cyc-4];
      if (rs | fl) last_edge = cyc;
      for (int k = 0; k < 2; k++) begin
        d = (k == 0) ? d0 : d1;
        h = (k == 0) ? h0 : h1;
        if (!en_v[k]) begin
          asrt[k] = INF; deas[k] = INF;
        end else if (rs) begin
          if (act_m(k, cyc)) deas[k] = INF;
          else begin asrt[k] = cyc + 1 + d; deas[k] = INF; end
          hl[k] = h;
        end else if (fl && asrt[k] != INF && deas[k] == INF) begin
          if (cyc < asrt[k]) asrt[k] = INF;
          else deas[k] = cyc + 1 + hl[k];
        end
      end
    end
  endtask

  task automatic release_rst();
    @(negedge clk);
    cyc++;
    rst_n = 1'b1;
    for (int i = 0; i <= 4; i++) pin_h[cyc-i] = e;
    for (int k = 0; k < 2; k++) begin asrt[k] = INF; deas[k] = INF; hl[k] = 0; end
    last_edge = cyc - 1;
    rel_cyc   = cyc;
    model_ok  = 1'b1;
  endtask

  initial begin
    int n, on0, on1, first, gap, t_up, t_clr, p, q;
    int e_run, rd0, rh0, rd1, rh1;
    int off_cnt [2];
    logic e_cur;
    logic [1:0] en_r;

    tbl[0] = '{d:0,   h:4,   hi:50,  lo:50,  exp_on:54,  exp_off:4};
    tbl[1] = '{d:44,  h:0,   hi:50,  lo:50,  exp_on:6,   exp_off:48};
    tbl[2] = '{d:20,  h:5,   hi:10,  lo:30,  exp_on:0,   exp_off:-1};
    tbl[3] = '{d:9,   h:0,   hi:10,  lo:20,  exp_on:1,   exp_off:13};
    tbl[4] = '{d:10,  h:3,   hi:10,  lo:20,  exp_on:0,   exp_off:-1};
    tbl[5] = '{d:127, h:127, hi:128, lo:140, exp_on:128, exp_off:131};
    tbl[6] = '{d:1,   h:1,   hi:5,   lo:10,  exp_on:5,   exp_off:5};

    for (int i = 0; i < 32768; i++) pin_h[i] = 1'b0;

    // Reset values
    for (int i = 0; i < 3; i++) step(1'b0, 2'b11, 0, 0, 0, 0);
    chk("rst_en", 64'(o_en), 64'(2'b10));
    chk("rst_e_sync", 64'(o_e_sync), 64'(0));
    chk("rst_timeout", 64'(o_e_timeout), 64'(0));
    release_rst();
    for (int i = 0; i < 10; i++) step(1'b0, 2'b11, 0, 0, 0, 0);

    // Table: single E period on ch0
    for (int r = 0; r < 7; r++) begin
      for (int i = 0; i < 10; i++) step(1'b0, 2'b11, tbl[r].d, tbl[r].h, tbl[r].d, tbl[r].h);
      on0 = 0; first = -1; n = cyc + 1;
      for (int i = 0; i < tbl[r].hi + tbl[r].lo; i++) begin
        step(i < tbl[r].hi, 2'b11, tbl[r].d, tbl[r].h, tbl[r].d, tbl[r].h);
        if (o_en[0] === 1'b1) begin
          on0++;
          if (first < 0) first = cyc - n;
        end
      end
      chk($sformatf("tbl%0d_on", r), 64'(on0), 64'(tbl[r].exp_on));
      chk($sformatf("tbl%0d_off", r), 64'(first), 64'(tbl[r].exp_off));
    end

    // 1 MHz E, ch0 0/4 and ch1 44/0
    for (int i = 0; i < 60; i++) step(1'b0, 2'b11, 0, 4, 44, 0);
    on0 = 0; on1 = 0;
    for (int per = 0; per < 3; per++)
      for (int i = 0; i < 100; i++) begin
        step(i < 50, 2'b11, 0, 4, 44, 0);
        if (o_en[0] === 1'b1) on0++;
        if (o_en[1] === 1'b0) on1++;
      end
    chk("mhz_ch0_on", 64'(on0), 64'(162));
    chk("mhz_ch1_on", 64'(on1), 64'(18));

    // Short low gap inside the hold: windows merge
    for (int i = 0; i < 20; i++) step(1'b0, 2'b11, 0, 8, 0, 8);
    n = cyc + 1; gap = 0;
    for (int i = 0; i < 50; i++) begin
      step(!(i >= 20 && i < 23), 2'b11, 0, 8, 0, 8);
      if ((cyc - n) >= 10 && (cyc - n) <= 42 && o_en[0] !== 1'b1) gap++;
    end
    chk("merge_gap", 64'(gap), 64'(0));

    // Channel enable drop mid-window on active-low ch1
    for (int i = 0; i < 20; i++) step(1'b0, 2'b11, 0, 0, 0, 0);
    for (int i = 0; i < 12; i++) step(1'b1, 2'b11, 0, 0, 0, 0);
    chk("chen_pre", 64'(o_en[1]), 64'(0));
    step(1'b1, 2'b01, 0, 0, 0, 0);
    step(1'b1, 2'b11, 0, 0, 0, 0);
    chk("chen_drop", 64'(o_en[1]), 64'(1));
    for (int i = 0; i < 10; i++) step(1'b1, 2'b11, 0, 0, 0, 0);
    chk("chen_reen", 64'(o_en[1]), 64'(1));

    // Reset in the middle of an active window, release with E high
    for (int i = 0; i < 20; i++) step(1'b0, 2'b11, 0, 0, 0, 0);
    for (int i = 0; i < 12; i++) step(1'b1, 2'b11, 0, 0, 0, 0);
    #2 rst_n = 1'b0;
    model_ok = 1'b0;
    #1 chk("rst_async_en", 64'(o_en), 64'(2'b10));
    for (int i = 0; i < 4; i++) step(1'b1, 2'b11, 0, 0, 0, 0);
    chk("rst_mid_sync", 64'(o_e_sync), 64'(0));
    release_rst();
    on0 = 0;
    for (int i = 0; i < 15; i++) begin
      step(1'b1, 2'b11, 0, 0, 0, 0);
      if (o_en[0] === 1'b1) on0++;
    end
    chk("rst_no_assert", 64'(on0), 64'(0));
    for (int i = 0; i < 10; i++) step(1'b0, 2'b11, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) step(1'b1, 2'b11, 0, 0, 0, 0);
    chk("rst_fresh_rise", 64'(o_en[0]), 64'(1));

    // Watchdog
    for (int i = 0; i < 10; i++) step(1'b0, 2'b11, 5, 5, 5, 5);
    step(1'b1, 2'b11, 5, 5, 5, 5);
    p = cyc; t_up = -1;
    for (int i = 0; i < 4200; i++) begin
      step(1'b1, 2'b11, 5, 5, 5, 5);
      if (t_up < 0 && o_e_timeout === 1'b1) t_up = cyc;
    end
    chk("to_rise_lat", 64'(t_up - p), 64'(4099));
    step(1'b0, 2'b11, 5, 5, 5, 5);
    q = cyc; t_clr = -1;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 2'b11, 5, 5, 5, 5);
      if (t_clr < 0 && o_e_timeout === 1'b0) t_clr = cyc;
    end
    chk("to_clear_lat", 64'(t_clr - q), 64'(4));

    // Random E waveform, configs and channel enables against the model
    e_cur = 1'b0; e_run = 10;
    rd0 = 3; rh0 = 3; rd1 = 10; rh1 = 0;
    off_cnt[0] = 0; off_cnt[1] = 0;
    for (int i = 0; i < 5000; i++) begin
      if (e_run == 0) begin
        e_cur = ~e_cur;
        e_run = $urandom_range(1, 80);
      end
      e_run--;
      if ($urandom_range(0, 39) == 0) begin
        rd0 = ($urandom_range(0, 9) == 0) ? 127 : $urandom_range(0, 60);
        rh0 = $urandom_range(0, 40);
        rd1 = $urandom_range(0, 60);
        rh1 = ($urandom_range(0, 9) == 0) ? 127 : $urandom_range(0, 40);
      end
      for (int k = 0; k < 2; k++) begin
        if (off_cnt[k] > 0) off_cnt[k]--;
        else if ($urandom_range(0, 199) == 0) off_cnt[k] = $urandom_range(1, 20);
        en_r[k] = (off_cnt[k] == 0);
      end
      step(e_cur, en_r, rd0, rh0, rd1, rh1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
